rst_seq_ctrl: RTL and testbench
===============================

// Module: rst_seq_ctrl
// PURPOSE
//   Reset sequencer for multi-domain designs and benches. After the root reset (e.g. from clk_rst_gen)
//   deasserts, it releases NumDomains downstream active-low resets one at a time, GapCycles apart.
//   Afterwards it accepts valid/ready requests that re-reset a single domain for HoldCycles cycles.
//   Sits between the root clock/reset source and per-domain reset inputs.
// PARAMETERS
//   NumDomains  4  number of sequenced reset domains (>=1)
//   GapCycles   5  cycles between successive releases during boot (>=1)
//   HoldCycles  5  cycles a software-requested domain reset stays asserted (>=1)
// PORTS
//   clk_i           in   1                     clock; the only clock
//   rst_ni          in   1                     root reset, synchronous, active-low
//   rst_no          out  NumDomains            per-domain reset, active-low, registered
//   all_released_o  out  1                     1 when every rst_no bit is high
//   req_valid_i     in   1                     domain reset request
//   req_ready_o     out  1                     request accepted when valid&ready at a rising edge
//   req_domain_i    in   $clog2(NumDomains)+1  target domain index
//   done_o          out  1                     1-cycle pulse when a request completes
//   err_o           out  1                     1-cycle pulse, with done_o, for out-of-range index
// BEHAVIOUR
//   - Reset: clk_i is the only clock; rst_ni is synchronous and active-low. rst_ni=0 sampled at any
//     edge, in any state: rst_no='0, all_released_o=0, req_ready_o=0, done_o=0, err_o=0,
//     state=BOOT, timer=0, idx=0.
//   - FSM states: BOOT, RUN, HOLD. Only one request is in flight at a time.
//   - BOOT:
//       edge 1 = first edge sampling rst_ni=1.
//       rst_no[k] goes high after edge (k+1)*GapCycles; lower indices are released first.
//       After the last domain is released: state=RUN and all_released_o=1 on that same edge.
//       req_ready_o=0 throughout BOOT; a held valid simply stalls.
//   - RUN:
//       req_ready_o=1 (Moore output; does not depend on valid).
//       Handshake at edge T with index d<NumDomains: rst_no[d]=0 after T, state=HOLD, timer=HoldCycles,
//       all_released_o=0.
//       Handshake with d>=NumDomains: no reset; done_o=err_o=1 after T for one cycle; stay in RUN.
//   - HOLD:
//       req_ready_o=0; rst_no[d] stays low after edges T..T+HoldCycles-1.
//       At edge T+HoldCycles: rst_no[d]=1, all_released_o=1, done_o=1 (one cycle), state=RUN.
//       A valid held since HOLD is accepted at edge T+HoldCycles+1 at the earliest.
//   - Other domains are never disturbed by a request.
//   - Requester contract: req_valid_i and req_domain_i stay stable until accepted. The bench asserts this.
//   - Timer: a down-counter of width $clog2(max(GapCycles,HoldCycles)+1), reloaded on each event.
//     It never wraps; expiry is timer==1 at the decrementing edge.
//   - Elaboration error if NumDomains, GapCycles or HoldCycles is 0.
// STRUCTURE
//   - rst_seq_pkg: state_e {BOOT, RUN, HOLD}.
//   - Sub-module rst_seq_timer: load/enable/expire down-counter, parameterised width, shared by the
//     BOOT and HOLD states.
//   - Top level: FSM, domain index register, registered outputs.
// TESTING (clk_rst_gen drives clk_i/rst_ni; defaults 4/5/5)
//   - Boot: rst_no = 0001, 0011, 0111, 1111 after edges 5, 10, 15, 20.
//     all_released_o rises at edge 20; req_ready_o=1 from edge 20.
//   - Valid held from edge 2 with d=1: no acceptance before edge 21.
//     rst_no[1] low after edges 21..25; released and done_o pulses at edge 26.
//   - Request d=2 accepted at edge 30: rst_no=1011 after edges 30..34; 1111 plus done_o at 35.
//     err_o stays 0.
//   - Request d=5 accepted at edge 40: done_o=err_o=1 after edge 40 only; rst_no stays 1111.
//   - Back-to-back d=0 then d=3 with valid held: second accept at edge T+6; no overlap of low resets.
//   - rst_ni=0 at edge 32, during HOLD: all outputs 0 after 32. Release at edge 34 restarts BOOT;
//     rst_no[0] rises after edge 38.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// Purpose: shared types and helpers for the reset sequencer.
//   state_e  : sequencer FSM states
//   max_int  : constant-evaluable maximum, used for timer sizing
package rst_seq_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_seq_ctrl_if.sv
// Purpose: request handshake between a requester and the reset sequencer.
//   req_valid  : requester wants a domain re-reset
//   req_ready  : sequencer can accept; transfer on valid & ready at a rising edge
//   req_domain : target domain index (held stable until accepted)
//   done       : 1-cycle pulse when a request completes
//   err        : 1-cycle pulse, together with done, for an out-of-range index
interface rst_seq_ctrl_if #(
  parameter int DomW = 3
);
  logic            req_valid;
  logic            req_ready;
  logic [DomW-1:0] req_domain;
  logic            done;
  logic            err;

  modport master (output req_valid, req_domain, input req_ready, done, err);
  modport slave  (input req_valid, req_domain, output req_ready, done, err);
endinterface

// File: rtl/rst_seq_timer.sv
// Purpose: loadable down-counter that saturates at zero.
//   clk      : clock
//   rst_n    : synchronous active-low reset (count -> 0)
//   load     : load load_val (has priority over en)
//   load_val : reload value
//   en       : decrement enable
//   cnt      : current count
//   expire   : en asserted while cnt == 1 (the decrementing edge that ends the interval)
module rst_seq_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         expire
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = en && (cnt == W'(1));

endmodule

// File: rtl/rst_seq_ctrl.sv
// Purpose: releases NumDomains active-low resets one at a time, GapCycles
//   apart, after the root reset deasserts; then services single-domain
//   re-reset requests, holding the domain in reset for HoldCycles cycles.
// Ports:
//   clk_i          : clock (only clock)
//   rst_ni         : root reset, synchronous, active-low
//   rst_no         : per-domain resets, active-low, registered
//   all_released_o : 1 when every rst_no bit is high
//   req            : request handshake (slave side), see rst_seq_ctrl_if
//
// state | meaning
// BOOT  | releasing domains in index order, one per GapCycles
// RUN   | all domains released, ready for a request
// HOLD  | one requested domain held in reset for HoldCycles
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int NumDomains = 4,
  parameter int GapCycles  = 5,
  parameter int HoldCycles = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  output logic [NumDomains-1:0] rst_no,
  output logic                  all_released_o,
  rst_seq_ctrl_if.slave         req
);

  localparam int DomW = $clog2(NumDomains) + 1;
  localparam int IdxW = (NumDomains > 1) ? $clog2(NumDomains) : 1;
  localparam int TW   = $clog2(max_int(GapCycles, HoldCycles) + 1);

  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumDomains - 1);
  localparam logic [DomW-1:0] NumDom  = DomW'(NumDomains);
  localparam logic [TW-1:0]   GapV    = TW'(GapCycles);
  localparam logic [TW-1:0]   GapM1   = TW'(GapCycles - 1);
  localparam logic [TW-1:0]   HoldV   = TW'(HoldCycles);

  if (NumDomains < 1 || GapCycles < 1 || HoldCycles < 1) begin : g_param_check
    $error("rst_seq_ctrl: NumDomains, GapCycles and HoldCycles must all be >= 1");
  end

  state_e          state;
  logic [IdxW-1:0] idx;
  logic            ready_q;
  logic            done_q;
  logic            err_q;

  logic            t_load;
  logic [TW-1:0]   t_load_val;
  logic            t_en;
  logic [TW-1:0]   t_cnt;
  logic            t_expire;

  logic            boot_first;
  logic            boot_fire;
  logic            accept;
  logic            in_range;
  logic [IdxW-1:0] dom_idx;

  assign accept   = (state == RUN) && req.req_valid && ready_q;
  assign in_range = req.req_domain < NumDom;
  assign dom_idx  = req.req_domain[IdxW-1:0];

  // The timer is zero only on the first boot edge after root reset; that
  // edge already counts as one gap cycle, hence the GapCycles-1 load.
  assign boot_first = (state == BOOT) && (t_cnt == '0);
  assign boot_fire  = (state == BOOT) && (boot_first ? (GapCycles == 1) : t_expire);

  always_comb begin
    t_load     = 1'b0;
    t_load_val = GapV;
    t_en       = (state == BOOT) || (state == HOLD);
    if (state == BOOT) begin
      if (boot_fire) begin
        t_load = (idx != LastIdx);
      end else if (boot_first) begin
        t_load     = 1'b1;
        t_load_val = GapM1;
      end
    end else if (accept && in_range) begin
      t_load     = 1'b1;
      t_load_val = HoldV;
    end
  end

  rst_seq_timer #(.W(TW)) u_timer (
    .clk      (clk_i),
    .rst_n    (rst_ni),
    .load     (t_load),
    .load_val (t_load_val),
    .en       (t_en),
    .cnt      (t_cnt),
    .expire   (t_expire)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state          <= BOOT;
      idx            <= '0;
      rst_no         <= '0;
      all_released_o <= 1'b0;
      ready_q        <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        BOOT: begin
          if (boot_fire) begin
            rst_no[idx] <= 1'b1;
            if (idx == LastIdx) begin
              state          <= RUN;
              all_released_o <= 1'b1;
              ready_q        <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        RUN: begin
          if (accept) begin
            if (in_range) begin
              rst_no[dom_idx] <= 1'b0;
              idx             <= dom_idx;
              all_released_o  <= 1'b0;
              ready_q         <= 1'b0;
              state           <= HOLD;
            end else begin
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (t_expire) begin
            rst_no[idx]    <= 1'b1;
            all_released_o <= 1'b1;
            done_q         <= 1'b1;
            ready_q        <= 1'b1;
            state          <= RUN;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

  assign req.req_ready = ready_q;
  assign req.done      = done_q;
  assign req.err       = err_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
module tb_rst_seq_ctrl;

  logic       clk;
  logic       rst_n;
  logic [3:0] rst_no;
  logic       all_rel;

  rst_seq_ctrl_if #(.DomW(3)) ifc ();

  rst_seq_ctrl #(
    .NumDomains (4),
    .GapCycles  (5),
    .HoldCycles (5)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .rst_no         (rst_no),
    .all_released_o (all_rel),
    .req            (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] d;
    int         due;
    logic       err;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   edge_n = 0;
  int   mode = 0;     // 0: root reset, 1: boot, 2: run (scoreboard)
  int   last_acc = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h at edge %0d", tag, obs, expv, edge_n);
    end
  endtask

  function automatic logic [3:0] boot_exp(input int e);
    if (e < 5)       return 4'b0000;
    else if (e < 10) return 4'b0001;
    else if (e < 15) return 4'b0011;
    else if (e < 20) return 4'b0111;
    else             return 4'b1111;
  endfunction

  task automatic cycle();
    logic       acc;
    logic [3:0] er;
    exp_t       e;
    acc = ifc.req_valid && ifc.req_ready && rst_n;
    @(posedge clk);
    edge_n++;
    #1;
    if (acc) begin
      last_acc = edge_n;
      e.d = ifc.req_domain;
      if (ifc.req_domain < 3'd4) begin
        e.due = edge_n + 5;
        e.err = 1'b0;
      end else begin
        e.due = edge_n;
        e.err = 1'b1;
      end
      q.push_back(e);
      ifc.req_valid = 1'b0;
    end
    if (mode == 1 && edge_n >= 20) mode = 2;
    case (mode)
      0: begin
        chk("rst_rst_no", rst_no, 4'b0000);
        chk("rst_all", all_rel, 1'b0);
        chk("rst_ready", ifc.req_ready, 1'b0);
        chk("rst_done", ifc.done, 1'b0);
        chk("rst_err", ifc.err, 1'b0);
      end
      1: begin
        chk("boot_rst_no", rst_no, boot_exp(edge_n));
        chk("boot_all", all_rel, 1'b0);
        chk("boot_ready", ifc.req_ready, 1'b0);
        chk("boot_done", ifc.done, 1'b0);
      end
      default: begin
        if (q.size() > 0 && q[0].due == edge_n) begin
          e = q.pop_front();
          chk("done_pulse", ifc.done, 1'b1);
          chk("err_pulse", ifc.err, e.err);
        end else begin
          chk("done_idle", ifc.done, 1'b0);
          chk("err_idle", ifc.err, 1'b0);
        end
        er = 4'b1111;
        if (q.size() > 0 && !q[0].err) er[q[0].d[1:0]] = 1'b0;
        chk("run_rst_no", rst_no, er);
        chk("run_all", all_rel, (er == 4'b1111));
        chk("run_ready", ifc.req_ready, (er == 4'b1111));
      end
    endcase
  endtask

  task automatic run_to(input int n);
    while (edge_n < n) cycle();
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((ifc.req_valid || q.size() > 0) && n < budget) begin
      cycle();
      n++;
    end
    chk("idle_timeout", (ifc.req_valid || q.size() > 0), 1'b0);
  endtask

  initial begin
    rst_n          = 1'b0;
    ifc.req_valid  = 1'b0;
    ifc.req_domain = 3'd0;
    mode           = 0;
    repeat (3) cycle();

    // boot; request for domain 1 held from edge 2
    rst_n  = 1'b1;
    mode   = 1;
    edge_n = 0;
    cycle();
    ifc.req_domain = 3'd1;
    ifc.req_valid  = 1'b1;
    wait_idle(40);
    chk("acc_d1_edge", last_acc, 21);
    chk("d1_done_edge", edge_n, 26);

    run_to(29);
    ifc.req_domain = 3'd2;
    ifc.req_valid  = 1'b1;
    cycle();
    chk("acc_d2_edge", last_acc, 30);
    wait_idle(20);
    chk("d2_done_edge", edge_n, 35);

    // out-of-range index
    run_to(39);
    ifc.req_domain = 3'd5;
    ifc.req_valid  = 1'b1;
    cycle();
    chk("acc_d5_edge", last_acc, 40);
    cycle();

    // back-to-back with valid held
    run_to(44);
    ifc.req_domain = 3'd0;
    ifc.req_valid  = 1'b1;
    cycle();
    chk("acc_d0_edge", last_acc, 45);
    ifc.req_domain = 3'd3;
    ifc.req_valid  = 1'b1;
    wait_idle(30);
    chk("acc_d3_edge", last_acc, 51);
    chk("d3_done_edge", edge_n, 56);

    // root reset during HOLD, then reboot
    run_to(59);
    ifc.req_domain = 3'd2;
    ifc.req_valid  = 1'b1;
    cycle();
    chk("acc_d2b_edge", last_acc, 60);
    cycle();
    rst_n = 1'b0;
    mode  = 0;
    q.delete();
    cycle();
    cycle();
    rst_n  = 1'b1;
    mode   = 1;
    edge_n = 0;
    repeat (22) cycle();
    chk("reboot_final", rst_no, 4'b1111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
